// File: rtl/d_sync_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : d_sync_debounce_if
// Description : Level/pulse bundle between the latch-side driver and the
//               synchronising debouncer.
// Revision    : 1.0  initial release
// ============================================================================
interface d_sync_debounce_if;
    logic d;
    logic en;
    logic q_stable;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output d,
        output en,
        input  q_stable,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  d,
        input  en,
        output q_stable,
        output rise,
        output fall,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/d_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : d_sync_debounce
// Description : Synchronises an asynchronous latched level into clk and
//               debounces it into a clean level plus rise/fall pulses.
// Revision    : 1.0  initial release
// ============================================================================
module d_sync_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    d_sync_debounce_if.slave   bus
);

    localparam int                 CNT_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0]   C_ZERO = '0;
    localparam logic [CNT_W-1:0]   C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   d_sync;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_stable_q, q_stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;

    assign sync_d[0] = bus.d;

    generate
        for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_sync
            assign sync_d[i] = sync_q[i-1];
        end
    endgenerate

    assign d_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= STABLE_LO;
            cnt_q      <= C_ZERO;
            q_stable_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_stable_q <= q_stable_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            busy_q     <= busy_d;
        end
    end

    // cnt counts enabled cycles the opposite level has been seen, including the first
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_stable_d = q_stable_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;

        if (bus.en) begin
            case (state_q)
                STABLE_LO: begin
                    if (d_sync) begin
                        if (DEBOUNCE_CNT == 1) begin
                            state_d    = STABLE_HI;
                            q_stable_d = 1'b1;
                            rise_d     = 1'b1;
                            cnt_d      = C_ZERO;
                        end else begin
                            state_d = CHECK_HI;
                            cnt_d   = C_ONE;
                        end
                    end
                end
                CHECK_HI: begin
                    if (!d_sync) begin
                        state_d = STABLE_LO;
                        cnt_d   = C_ZERO;
                    end else if (cnt_q == C_LAST) begin
                        state_d    = STABLE_HI;
                        q_stable_d = 1'b1;
                        rise_d     = 1'b1;
                        cnt_d      = C_ZERO;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!d_sync) begin
                        if (DEBOUNCE_CNT == 1) begin
                            state_d    = STABLE_LO;
                            q_stable_d = 1'b0;
                            fall_d     = 1'b1;
                            cnt_d      = C_ZERO;
                        end else begin
                            state_d = CHECK_LO;
                            cnt_d   = C_ONE;
                        end
                    end
                end
                CHECK_LO: begin
                    if (d_sync) begin
                        state_d = STABLE_HI;
                        cnt_d   = C_ZERO;
                    end else if (cnt_q == C_LAST) begin
                        state_d    = STABLE_LO;
                        q_stable_d = 1'b0;
                        fall_d     = 1'b1;
                        cnt_d      = C_ZERO;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                default: begin
                    state_d    = STABLE_LO;
                    cnt_d      = C_ZERO;
                    q_stable_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == CHECK_HI) || (state_d == CHECK_LO);
    end

    assign bus.q_stable = q_stable_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_d_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_sync_debounce
// Description : Directed bench for d_sync_debounce (default build and a
//               DEBOUNCE_CNT=1 build) against a run-length reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_d_sync_debounce;

    localparam int SYNC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_pass  = 0;
    int n_total = 0;
    bit rise_seen = 1'b0;

    always #5 clk = ~clk;

    d_sync_debounce_if if0 ();
    d_sync_debounce_if if1 ();

    assign if1.d  = if0.d;
    assign if1.en = if0.en;

    d_sync_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CNT(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    d_sync_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CNT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference: output flips once the synchronised input has differed from
    // it for LIM consecutive enabled cycles.
    int   lim   [2] = '{4, 1};
    logic m_q   [2] = '{1'b0, 1'b0};
    int   m_run [2] = '{0, 0};
    logic m_rise[2] = '{1'b0, 1'b0};
    logic m_fall[2] = '{1'b0, 1'b0};
    logic hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < 2; i++) begin
                m_q[i] = 1'b0; m_run[i] = 0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
            end
        end else begin
            logic ds;
            ds = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
            hist.push_back(if0.d);
            if (hist.size() > SYNC) void'(hist.pop_front());
            for (int i = 0; i < 2; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (if0.en) begin
                    if (ds != m_q[i]) begin
                        m_run[i]++;
                        if (m_run[i] == lim[i]) begin
                            m_q[i]    = ds;
                            m_rise[i] = ds;
                            m_fall[i] = ~ds;
                            m_run[i]  = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("q_stable0", if0.q_stable, m_q[0]);
        chk("rise0",     if0.rise,     m_rise[0]);
        chk("fall0",     if0.fall,     m_fall[0]);
        chk("busy0",     if0.busy,     m_run[0] > 0);
        chk("q_stable1", if1.q_stable, m_q[1]);
        chk("rise1",     if1.rise,     m_rise[1]);
        chk("fall1",     if1.fall,     m_fall[1]);
        chk("busy1",     if1.busy,     m_run[1] > 0);
        if (if0.rise === 1'b1) rise_seen = 1'b1;
    end

    task automatic waitn(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        if0.d  = 1'b0;
        if0.en = 1'b1;

        // Reset asserted between edges: outputs clear without a clock
        #3 rst_n = 1'b0;
        #1;
        chk("rst_q",    if0.q_stable, 1'b0);
        chk("rst_rise", if0.rise,     1'b0);
        chk("rst_fall", if0.fall,     1'b0);
        chk("rst_busy", if0.busy,     1'b0);
        waitn(2);
        rst_n = 1'b1;
        waitn(10);
        chk("idle_q", if0.q_stable, 1'b0);
        chk("idle_no_rise", rise_seen, 1'b0);

        // Clean rise; k = first edge sampling the new d
        if0.d = 1'b1;
        waitn(1);                                   // after k
        chk("r_busy_k", if0.busy, 1'b0);
        waitn(1);                                   // k+1
        chk("r_busy_k1", if0.busy, 1'b0);
        waitn(1);                                   // k+2
        chk("r_busy_k2", if0.busy, 1'b1);
        chk("r1_q_k2",    if1.q_stable, 1'b1);
        chk("r1_rise_k2", if1.rise,     1'b1);
        waitn(2);                                   // k+4
        chk("r_busy_k4", if0.busy, 1'b1);
        chk("r_q_k4",    if0.q_stable, 1'b0);
        waitn(1);                                   // k+5
        chk("r_q_k5",    if0.q_stable, 1'b1);
        chk("r_rise_k5", if0.rise,     1'b1);
        chk("r_busy_k5", if0.busy,     1'b0);
        waitn(1);                                   // k+6
        chk("r_rise_k6", if0.rise,     1'b0);
        chk("r_q_k6",    if0.q_stable, 1'b1);

        // Clean fall
        if0.d = 1'b0;
        waitn(5);                                   // k+4
        chk("f_fall_k4", if0.fall, 1'b0);
        waitn(1);                                   // k+5
        chk("f_fall_k5", if0.fall,     1'b1);
        chk("f_q_k5",    if0.q_stable, 1'b0);
        waitn(1);
        chk("f_fall_k6", if0.fall, 1'b0);

        // Two-cycle glitch is rejected
        waitn(3);
        rise_seen = 1'b0;
        if0.d = 1'b1;
        waitn(2);
        if0.d = 1'b0;
        waitn(10);
        chk("g_q",       if0.q_stable, 1'b0);
        chk("g_busy",    if0.busy,     1'b0);
        chk("g_no_rise", rise_seen,    1'b0);

        // Freeze in CHECK_HI with cnt=2
        if0.d = 1'b1;
        waitn(4);                                   // k+3
        if0.en = 1'b0;
        waitn(7);
        chk("z_q",    if0.q_stable, 1'b0);
        chk("z_busy", if0.busy,     1'b1);
        if0.en = 1'b1;
        waitn(1);
        chk("z_q_1", if0.q_stable, 1'b0);
        waitn(1);
        chk("z_q_2",    if0.q_stable, 1'b1);
        chk("z_rise_2", if0.rise,     1'b1);

        // Disabled while the input changes: nothing moves
        if0.en = 1'b0;
        if0.d  = 1'b0;
        waitn(8);
        chk("en0_q", if0.q_stable, 1'b1);
        if0.en = 1'b1;
        waitn(8);
        chk("en1_q", if0.q_stable, 1'b0);

        // Reset in the middle of a check (cnt=3)
        if0.d = 1'b1;
        waitn(5);                                   // k+4
        chk("m_busy", if0.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("m_rst_busy", if0.busy,     1'b0);
        chk("m_rst_q",    if0.q_stable, 1'b0);
        rise_seen = 1'b0;
        if0.d = 1'b0;
        waitn(2);
        rst_n = 1'b1;
        waitn(8);
        chk("m_q_after",  if0.q_stable, 1'b0);
        chk("m_no_rise",  rise_seen,    1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
